// File: rtl/pwm_duty_top.sv
// pwm_duty_top: button-adjusted PWM generator behind an 8-bit io_in/io_out pad wrapper
module pwm_duty_top #(
  parameter int PERIOD          = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_DUTY      = 5
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam int DW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic          w_clk;
  logic          w_rst;
  logic [1:0]    w_btn;
  logic          w_unused;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_db;
  logic [1:0]    r_ev;
  logic [CW-1:0] r_dbc [2];
  logic [DW-1:0] r_duty;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_active;
  logic          r_pwm;
  logic [DW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_act_nxt;
  assign w_clk    = io_in[0];
  assign w_rst    = io_in[3];
  assign w_btn    = io_in[2:1];
  assign w_unused = &{1'b0, io_in[7:4]};
  // Synchronize both buttons, debounce them, and emit a one-cycle pulse on each accepted rising level
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_db <= '0;
      r_ev <= '0;
      for (int k = 0; k < 2; k++) r_dbc[k] <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      for (int k = 0; k < 2; k++) begin
        if (r_s2[k] != r_db[k]) begin
          if (r_dbc[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[k]  <= r_s2[k];
            r_dbc[k] <= '0;
            r_ev[k]  <= r_s2[k];
          end else begin
            r_dbc[k] <= r_dbc[k] + CW'(1);
            r_ev[k]  <= 1'b0;
          end
        end else begin
          r_dbc[k] <= '0;
          r_ev[k]  <= 1'b0;
        end
      end
    end
  end
  // Step the duty by one per press event, saturating at both ends; simultaneous presses cancel
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst)
      r_duty <= DW'(RESET_DUTY);
    else if (r_ev[0] && !r_ev[1] && r_duty != DW'(PERIOD))
      r_duty <= r_duty + DW'(1);
    else if (r_ev[1] && !r_ev[0] && r_duty != '0)
      r_duty <= r_duty - DW'(1);
  end
  // Next counter value; the shadow duty is only refreshed when a new period starts
  always_comb begin
    w_cnt_nxt = (r_cnt == DW'(PERIOD - 1)) ? '0 : r_cnt + DW'(1);
    w_act_nxt = (w_cnt_nxt == '0) ? r_duty : r_active;
  end
  // Period counter, shadow duty and registered PWM level, kept so that r_pwm == (r_cnt < r_active)
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_cnt    <= '0;
      r_active <= DW'(RESET_DUTY);
      r_pwm    <= (RESET_DUTY > 0);
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_active <= w_act_nxt;
      r_pwm    <= w_cnt_nxt < w_act_nxt;
    end
  end
  assign io_out = {2'b00, 4'(r_duty), ~r_pwm, r_pwm};
endmodule

// File: tb/tb_pwm_duty_top.sv
// tb_pwm_duty_top: directed scoreboard bench for the button-driven PWM generator
module tb_pwm_duty_top;
  typedef struct {
    string tag;
    int    duty;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  assign io_in = {4'b0000, rst, dec, inc, clk};
  pwm_duty_top dut (.io_in(io_in), .io_out(io_out));
  always #5 clk = ~clk;
  function automatic void push(input string t, input int d);
    exp_t e;
    e.tag  = t;
    e.duty = d;
    q.push_back(e);
  endfunction
  task automatic cmp(input string t, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, exp);
    end
  endtask
  task automatic grab(output logic [9:0] p, output bit cok);
    cok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p[i] = io_out[0];
      if (io_out[1] !== ~io_out[0]) cok = 1'b0;
      @(negedge clk);
      #1;
    end
  endtask
  task automatic press(input bit i, input bit d, input int hold);
    inc = i;
    dec = d;
    repeat (hold) @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic check();
    exp_t       e;
    logic [9:0] p;
    bit         cok;
    e = q.pop_front();
    repeat (25) @(negedge clk);
    #1;
    cmp({e.tag, "_duty"}, int'(io_out[5:2]), e.duty);
    grab(p, cok);
    cmp({e.tag, "_high"}, $countones(p), e.duty);
    cmp({e.tag, "_compl"}, int'(cok), 1);
  endtask
  task automatic reset_pattern(input string t);
    logic [9:0] p;
    bit         cok;
    cmp({t, "_io_out"}, int'(io_out), 8'h15);
    @(negedge clk);
    rst = 1'b0;
    #1;
    grab(p, cok);
    cmp({t, "_pattern"}, int'(p), 10'b00000_11111);
    cmp({t, "_compl"}, int'(cok), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    reset_pattern("por");
    cmp("por_top_bits", int'(io_out[7:6]), 0);
    push("hold_inc", 6);
    press(1'b1, 1'b0, 20);
    check();
    push("bounce_inc", 7);
    inc = 1'b1; repeat (2) @(negedge clk);
    inc = 1'b0; repeat (1) @(negedge clk);
    inc = 1'b1; repeat (1) @(negedge clk);
    inc = 1'b0; repeat (2) @(negedge clk);
    inc = 1'b1; repeat (2) @(negedge clk);
    inc = 1'b0; repeat (1) @(negedge clk);
    press(1'b1, 1'b0, 20);
    check();
    push("glitch", 7);
    press(1'b1, 1'b0, 2);
    check();
    push("sat_high", 10);
    repeat (5) press(1'b1, 1'b0, 8);
    check();
    push("sat_low", 0);
    repeat (11) press(1'b0, 1'b1, 8);
    check();
    push("climb", 8);
    repeat (8) press(1'b1, 1'b0, 8);
    check();
    push("both", 8);
    press(1'b1, 1'b1, 20);
    check();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    reset_pattern("mid_rst");
    cmp("mid_rst_duty", int'(io_out[5:2]), 5);
    cmp("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
